// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared types and constants for the 8x8 DCT block scheduler
package dct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int PIX_W        = 8;
    localparam int ROWS_PER_BLK = 8;
    localparam int ROW_BUS_W    = PIX_W * ROWS_PER_BLK;

endpackage

// File: rtl/dct_block_sched_if.sv
// rtl/dct_block_sched_if.sv - pixel-row input and DCT-side handshake bundle
interface dct_block_sched_if;
    import dct_pkg::*;

    logic                 i_row_valid;
    logic [ROW_BUS_W-1:0] i_row_data;
    logic                 o_row_ready;
    logic                 o_dct_valid;
    logic [ROW_BUS_W-1:0] o_dct_data;
    logic                 i_dct_out_valid;

    modport master (
        output i_row_valid, i_row_data, i_dct_out_valid,
        input  o_row_ready, o_dct_valid, o_dct_data
    );

    modport slave (
        input  i_row_valid, i_row_data, i_dct_out_valid,
        output o_row_ready, o_dct_valid, o_dct_data
    );

endinterface

// File: rtl/dct_credit_cnt.sv
// rtl/dct_credit_cnt.sv - in-flight block counter; simultaneous inc/dec cancel out
module dct_credit_cnt #(
    parameter  int MAX_INFLIGHT = 2,
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_cnt_nxt,
    output logic          o_full,
    output logic          o_empty
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_full    = (cnt_q == CW'(MAX_INFLIGHT));
    assign o_empty   = (cnt_q == '0);
    assign o_cnt     = cnt_q;
    assign o_cnt_nxt = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({i_inc, i_dec})
            2'b10:   if (!o_full)  cnt_d = cnt_q + 1'b1;
            2'b01:   if (!o_empty) cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dct_block_sched.sv
// rtl/dct_block_sched.sv - feeds 8x8 pixel blocks row by row into a 2-D DCT with credit flow control
// Optional stall statistics output enabled by DCT_SCHED_STATS_EN.
module dct_block_sched
    import dct_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_blocks_x,
    input  logic [CNT_W-1:0] i_blocks_y,
    dct_block_sched_if.slave bus,
    output logic [CNT_W-1:0] o_blk_x,
    output logic [CNT_W-1:0] o_blk_y,
    output logic [2:0]       o_row_idx,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_err
`ifdef DCT_SCHED_STATS_EN
    ,
    output logic [15:0]      o_stall_cnt
`endif
);

    localparam int             IW       = $clog2(MAX_INFLIGHT + 1);
    localparam logic [2:0]     LAST_ROW = 3'(ROWS_PER_BLK - 1);

    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     bx_q, bx_d, by_q, by_d;
    logic [CNT_W-1:0]     blk_x_q, blk_x_d, blk_y_q, blk_y_d;
    logic [2:0]           row_q, row_d;
    logic [2:0]           out_row_q, out_row_d;
    logic                 dct_valid_q, dct_valid_d;
    logic [ROW_BUS_W-1:0] dct_data_q, dct_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [IW-1:0] inflight, inflight_nxt;
    logic          cr_full, cr_empty, cr_inc, cr_dec;
    logic          row_ready, accept, blk_wrap, last_x, last_y;
    logic          start_ok, start_bad, ret_ok, ret_stray;

    // A new block may not begin while the DCT already holds the maximum number of blocks.
    assign row_ready = (state_q == ST_FEED) && !((row_q == 3'd0) && cr_full);
    assign accept    = bus.i_row_valid && row_ready;
    assign blk_wrap  = accept && (row_q == LAST_ROW);
    assign last_x    = (blk_x_q == bx_q - 1'b1);
    assign last_y    = (blk_y_q == by_q - 1'b1);
    assign start_ok  = (state_q == ST_IDLE) && i_start && (i_blocks_x != '0) && (i_blocks_y != '0);
    assign start_bad = (state_q == ST_IDLE) && i_start && ((i_blocks_x == '0) || (i_blocks_y == '0));
    assign ret_ok    = bus.i_dct_out_valid && !cr_empty;
    assign ret_stray = bus.i_dct_out_valid && cr_empty;
    assign cr_inc    = blk_wrap;
    assign cr_dec    = ret_ok && (out_row_q == LAST_ROW);

    dct_credit_cnt #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_credit (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_inc     (cr_inc),
        .i_dec     (cr_dec),
        .o_cnt     (inflight),
        .o_cnt_nxt (inflight_nxt),
        .o_full    (cr_full),
        .o_empty   (cr_empty)
    );

    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        blk_x_d     = blk_x_q;
        blk_y_d     = blk_y_q;
        row_d       = row_q;
        out_row_d   = ret_ok ? out_row_q + 1'b1 : out_row_q;
        dct_valid_d = accept;
        dct_data_d  = accept ? bus.i_row_data : dct_data_q;
        done_d      = 1'b0;
        err_d       = start_bad || ret_stray;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_FEED;
                    bx_d    = i_blocks_x;
                    by_d    = i_blocks_y;
                    blk_x_d = '0;
                    blk_y_d = '0;
                    row_d   = 3'd0;
                end
            end
            ST_FEED: begin
                if (accept) begin
                    row_d = row_q + 1'b1;
                    if (blk_wrap) begin
                        if (last_x) begin
                            blk_x_d = '0;
                            blk_y_d = blk_y_q + 1'b1;
                            if (last_y) state_d = ST_DRAIN;
                        end else begin
                            blk_x_d = blk_x_q + 1'b1;
                        end
                    end
                end
            end
            // Looking at the next count lets done follow the final return by one cycle.
            ST_DRAIN: begin
                if (inflight_nxt == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            bx_q        <= '0;
            by_q        <= '0;
            blk_x_q     <= '0;
            blk_y_q     <= '0;
            row_q       <= 3'd0;
            out_row_q   <= 3'd0;
            dct_valid_q <= 1'b0;
            dct_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            blk_x_q     <= blk_x_d;
            blk_y_q     <= blk_y_d;
            row_q       <= row_d;
            out_row_q   <= out_row_d;
            dct_valid_q <= dct_valid_d;
            dct_data_q  <= dct_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef DCT_SCHED_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if ((state_q == ST_FEED) && bus.i_row_valid && !row_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

    assign bus.o_row_ready = row_ready;
    assign bus.o_dct_valid = dct_valid_q;
    assign bus.o_dct_data  = dct_data_q;
    assign o_blk_x         = blk_x_q;
    assign o_blk_y         = blk_y_q;
    assign o_row_idx       = row_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_frame_done    = done_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_dct_block_sched.sv
// tb/tb_dct_block_sched.sv - directed scoreboard bench for dct_block_sched
module tb_dct_block_sched;
    import dct_pkg::*;

    localparam int MAXI = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] bx = '0, by = '0;
    logic [CW-1:0] blk_x, blk_y;
    logic [2:0]    row_idx;
    logic          busy, frame_done, err;
`ifdef DCT_SCHED_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    dct_block_sched_if bus ();

    dct_block_sched #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_blocks_x   (bx),
        .i_blocks_y   (by),
        .bus          (bus),
        .o_blk_x      (blk_x),
        .o_blk_y      (blk_y),
        .o_row_idx    (row_idx),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_err        (err)
`ifdef DCT_SCHED_STATS_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    bit m_feed, m_drain, m_done;
    int m_row, m_inf, m_out, m_x, m_y, m_bx, m_by, n_acc, n_base;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_feed = 0; m_drain = 0; m_done = 0;
        m_row = 0; m_inf = 0; m_out = 0; m_x = 0; m_y = 0;
        exp_q.delete();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_ready"}, 64'(bus.o_row_ready), 64'd0);
        chk({tag, "_dvalid"}, 64'(bus.o_dct_valid), 64'd0);
        chk({tag, "_ddata"}, bus.o_dct_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_blkx"}, 64'(blk_x), 64'd0);
        chk({tag, "_blky"}, 64'(blk_y), 64'd0);
        chk({tag, "_row"}, 64'(row_idx), 64'd0);
    endtask

    // One clock: predict the edge from current inputs, then compare all outputs after it.
    task automatic cyc();
        bit rdy, acc, inc, dec, err_e, done_e, idle;
        int nxt;
        @(negedge clk);
        idle = !m_feed && !m_drain && !m_done;
        rdy  = m_feed && !(m_row == 0 && m_inf == MAXI);
        chk("row_ready", 64'(bus.o_row_ready), 64'(rdy));
        acc = rdy && bus.i_row_valid;
        if (acc) begin
            exp_q.push_back(bus.i_row_data);
            n_acc++;
        end
        inc   = acc && (m_row == 7);
        dec   = bus.i_dct_out_valid && (m_inf != 0) && (m_out == 7);
        err_e = (bus.i_dct_out_valid && m_inf == 0) || (start && idle && (bx == 0 || by == 0));
        if (bus.i_dct_out_valid && m_inf != 0) m_out = (m_out + 1) % 8;
        nxt    = m_inf + int'(inc) - int'(dec);
        done_e = m_drain && (nxt == 0);
        m_done = done_e;
        if (done_e) m_drain = 0;
        if (acc) begin
            m_row = (m_row + 1) % 8;
            if (inc) begin
                if (m_x == m_bx - 1) begin
                    m_x = 0;
                    if (m_y == m_by - 1) begin
                        m_feed  = 0;
                        m_drain = 1;
                    end
                    m_y = (m_y + 1) % 256;
                end else begin
                    m_x++;
                end
            end
        end
        m_inf = nxt;
        if (start && idle && bx != 0 && by != 0) begin
            m_feed = 1; m_bx = int'(bx); m_by = int'(by);
            m_x = 0; m_y = 0; m_row = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (exp_q.size() > 0) begin
            chk("dct_valid", 64'(bus.o_dct_valid), 64'd1);
            chk("dct_data", bus.o_dct_data, exp_q.pop_front());
        end else begin
            chk("dct_valid", 64'(bus.o_dct_valid), 64'd0);
        end
        chk("frame_done", 64'(frame_done), 64'(done_e));
        chk("err", 64'(err), 64'(err_e));
        chk("busy", 64'(busy), 64'(m_feed || m_drain || m_done));
        chk("blk_x", 64'(blk_x), 64'(m_x));
        chk("blk_y", 64'(blk_y), 64'(m_y));
        chk("row_idx", 64'(row_idx), 64'(m_row));
        chk("inflight", 64'(dut.u_credit.cnt_q), 64'(m_inf));
    endtask

    task automatic run(int n, bit valid, bit ret);
        for (int i = 0; i < n; i++) begin
            bus.i_row_valid     = valid;
            bus.i_row_data      = {$urandom, $urandom};
            bus.i_dct_out_valid = ret;
            cyc();
        end
        bus.i_row_valid     = 1'b0;
        bus.i_dct_out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_row_valid     = 1'b0;
        bus.i_row_data      = '0;
        bus.i_dct_out_valid = 1'b0;
        model_reset();
        n_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // zero-width frame start is rejected
        start = 1'b1; bx = 8'd0; by = 8'd1;
        cyc();
        cyc();

        // stray DCT return while nothing is in flight
        run(1, 1'b0, 1'b1);

        // 1x1 frame: 8 rows in, 8 rows back, done one cycle after last return
        start = 1'b1; bx = 8'd1; by = 8'd1;
        cyc();
        n_base = n_acc;
        run(8, 1'b1, 1'b0);
        chk("1x1_rows_accepted", 64'(n_acc - n_base), 64'd8);
        run(8, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        // 3x1 frame with returns withheld: credit stall at row 0 of block index 2
        start = 1'b1; bx = 8'd3; by = 8'd1;
        cyc();
        n_base = n_acc;
        run(16, 1'b1, 1'b0);
        chk("3x1_rows_before_stall", 64'(n_acc - n_base), 64'd16);
        bus.i_row_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start = 1'b1; bx = 8'd1; by = 8'd1;
            end
            cyc();
        end
        chk("stall_ready", 64'(bus.o_row_ready), 64'd0);
        chk("stall_blk_x", 64'(blk_x), 64'd2);
        chk("stall_row", 64'(row_idx), 64'd0);
        chk("stall_rows_accepted", 64'(n_acc - n_base), 64'd16);
`ifdef DCT_SCHED_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd10);
`endif
        run(8, 1'b1, 1'b1);
        // next 8 cycles: last block fed while block 1 returns; row-7 accept meets 8th return
        run(8, 1'b1, 1'b1);
        chk("same_cycle_inc_dec_inflight", 64'(dut.u_credit.cnt_q), 64'd1);
        chk("3x1_rows_total", 64'(n_acc - n_base), 64'd24);
        run(8, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        // reset in the middle of a 2x2 frame at row 4
        start = 1'b1; bx = 8'd2; by = 8'd2;
        cyc();
        run(4, 1'b1, 1'b0);
        chk("pre_reset_row", 64'(row_idx), 64'd4);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fresh 1x1 frame completes after the abandoned one
        start = 1'b1; bx = 8'd1; by = 8'd1;
        cyc();
        run(8, 1'b1, 1'b0);
        run(8, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
